mat_a_reader: RTL and testbench

MAT_A_READER -- requirements
Module: mat_a_reader

---
 rtl/mat_a_reader.sv | 190 +++++++++++++++++++
 tb/tb_mat_a_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_a_reader.sv
`default_nettype none
// ============================================================================
// Module      : mat_a_reader
// Description : Reads an N x P matrix from a synchronous-read memory in
//               address order and streams it out as (data,row,col,last)
//               over a valid/ready interface through a 2-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_a_reader #(
   parameter int N  = 2,
   parameter int P  = 4,
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_done,
   input  logic          start,
   output logic [AW-1:0] addrb,
   input  logic [DW-1:0] doutb,
   output logic [DW-1:0] elem_data,
   output logic [7:0]    elem_row,
   output logic [7:0]    elem_col,
   output logic          elem_valid,
   input  logic          elem_ready,
   output logic          elem_last,
   output logic          busy,
   output logic          rd_done
);

   localparam int         E        = N * P;
   localparam logic [7:0] LAST_IDX = 8'(E - 1);
   localparam logic [7:0] LAST_COL = 8'(P - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t        state;
   state_t        state_nxt;

   // issue side: index/row/col of the next address to be issued
   logic [7:0]    issue_idx;
   logic [7:0]    issue_row;
   logic [7:0]    issue_col;
   logic          issue;
   logic          restart;

   // one read in flight: tags travel alongside the memory latency
   logic          fl_valid;
   logic [7:0]    fl_row;
   logic [7:0]    fl_col;
   logic          fl_last;

   // 2-entry output FIFO
   logic [DW-1:0] fifo_data [2];
   logic [7:0]    fifo_row  [2];
   logic [7:0]    fifo_col  [2];
   logic          fifo_last [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;

   logic          push;
   logic          pop;
   logic [2:0]    committed;

   assign pop  = elem_valid & elem_ready;
   assign push = fl_valid;

   // Slots already spoken for once this cycle's pop retires: buffered plus
   // in flight. Crediting the pop keeps one element per cycle with ready
   // high while still never exceeding two buffered-plus-outstanding.
   assign committed = {1'b0, count} - {2'b00, pop} + {2'b00, fl_valid};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and issue decision
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      restart   = 1'b0;
      case (state)
         IDLE: begin
            if (start && wr_done) begin
               state_nxt = FETCH;
               restart   = 1'b1;
            end
         end
         FETCH: begin
            if (committed < 3'd2) begin
               issue = 1'b1;
               if (issue_idx == LAST_IDX) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && elem_last) state_nxt = DONE;
         end
         DONE: begin
            if (start && wr_done) begin
               state_nxt = FETCH;
               restart   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address generation; addrb holds its last value between issues
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addrb     <= '0;
         issue_idx <= '0;
         issue_row <= '0;
         issue_col <= '0;
      end else if (restart) begin
         issue_idx <= '0;
         issue_row <= '0;
         issue_col <= '0;
      end else if (issue) begin
         addrb     <= AW'(issue_idx);
         issue_idx <= issue_idx + 8'd1;
         if (issue_col == LAST_COL) begin
            issue_col <= '0;
            issue_row <= issue_row + 8'd1;
         end else begin
            issue_col <= issue_col + 8'd1;
         end
      end
   end

   // Tag pipeline matching the one-cycle memory read latency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fl_valid <= 1'b0;
         fl_row   <= '0;
         fl_col   <= '0;
         fl_last  <= 1'b0;
      end else begin
         fl_valid <= issue;
         fl_row   <= issue_row;
         fl_col   <= issue_col;
         fl_last  <= (issue_idx == LAST_IDX);
      end
   end

   // Output FIFO: capture returning read data, retire on transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_row[i]  <= '0;
            fifo_col[i]  <= '0;
            fifo_last[i] <= 1'b0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= doutb;
            fifo_row[wr_ptr]  <= fl_row;
            fifo_col[wr_ptr]  <= fl_col;
            fifo_last[wr_ptr] <= fl_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Stream presents the FIFO head; fields read zero while empty
   always_comb begin
      elem_valid = (count != 2'd0);
      elem_data  = elem_valid ? fifo_data[rd_ptr] : '0;
      elem_row   = elem_valid ? fifo_row[rd_ptr]  : '0;
      elem_col   = elem_valid ? fifo_col[rd_ptr]  : '0;
      elem_last  = elem_valid & fifo_last[rd_ptr];
      busy       = (state == FETCH) || (state == DRAIN);
      rd_done    = (state == DONE);
   end

endmodule
`default_nettype wire

// File: tb/tb_mat_a_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_a_reader
// Description : Directed scoreboard bench for mat_a_reader (N=2, P=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_a_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_done;
   logic        start;
   logic [7:0]  addrb;
   logic [31:0] doutb;
   logic [31:0] elem_data;
   logic [7:0]  elem_row;
   logic [7:0]  elem_col;
   logic        elem_valid;
   logic        elem_ready;
   logic        elem_last;
   logic        busy;
   logic        rd_done;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  row;
      logic [7:0]  col;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          xfer_cnt = 0;
   int          cyc = 0;
   int          first_cyc = -1;
   int          last_cyc = -1;
   logic [31:0] mem [256];

   mat_a_reader #(.N(2), .P(4), .AW(8), .DW(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_done    (wr_done),
      .start      (start),
      .addrb      (addrb),
      .doutb      (doutb),
      .elem_data  (elem_data),
      .elem_row   (elem_row),
      .elem_col   (elem_col),
      .elem_valid (elem_valid),
      .elem_ready (elem_ready),
      .elem_last  (elem_last),
      .busy       (busy),
      .rd_done    (rd_done)
   );

   always #5 clk = ~clk;

   // memory read data follows the registered address
   assign doutb = mem[addrb];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic push_stream();
      for (int k = 0; k < 8; k++) begin
         exp_t e;
         e.data = 32'(k);
         e.row  = 8'(k / 4);
         e.col  = 8'(k % 4);
         e.last = (k == 7);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!rd_done && n < 200) begin
         step();
         n++;
      end
      check(tag, rd_done, 1);
   endtask

   // Monitor: pops the scoreboard on every transfer and checks stall stability
   logic  stall_pend = 1'b0;
   exp_t  hold;
   always @(negedge clk) begin
      if (reset) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            check("stall_valid", elem_valid, 1);
            check("stall_data",  elem_data,  hold.data);
            check("stall_rowcol", {elem_row, elem_col}, {hold.row, hold.col});
            check("stall_last",  elem_last,  hold.last);
         end
         if (elem_valid && elem_ready) begin
            xfer_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            check("xfer_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check("xfer_data", elem_data, e.data);
               check("xfer_row",  elem_row,  e.row);
               check("xfer_col",  elem_col,  e.col);
               check("xfer_last", elem_last, e.last);
            end
         end
         stall_pend = elem_valid && !elem_ready;
         hold.data  = elem_data;
         hold.row   = elem_row;
         hold.col   = elem_col;
         hold.last  = elem_last;
      end
   end

   initial begin
      logic [3:0] pat;
      pat = 4'b1001;
      for (int k = 0; k < 256; k++) mem[k] = 32'(k);
      reset      = 1'b1;
      wr_done    = 1'b0;
      start      = 1'b0;
      elem_ready = 1'b1;
      step();
      step();
      // reset state
      check("rst_addrb", addrb, 0);
      check("rst_valid", elem_valid, 0);
      check("rst_busy",  busy, 0);
      check("rst_done",  rd_done, 0);
      check("rst_fields", {elem_data, elem_row, elem_col, elem_last}, 0);
      reset = 1'b0;
      step();

      // start while memory not written is ignored
      pulse_start();
      for (int i = 0; i < 4; i++) step();
      check("nowr_busy",  busy, 0);
      check("nowr_addrb", addrb, 0);
      check("nowr_valid", elem_valid, 0);
      check("nowr_xfers", xfer_cnt, 0);

      // normal stream, ready held high
      wr_done = 1'b1;
      push_stream();
      xfer_cnt = 0; first_cyc = -1;
      pulse_start();
      check("run1_busy", busy, 1);
      wr_done = 1'b0;               // ignored once accepted
      for (int i = 0; i < 3 && !elem_valid; i++) step();
      check("run1_latency", elem_valid, 1);
      wait_done("run1_done");
      check("run1_xfers", xfer_cnt, 8);
      check("run1_throughput", last_cyc - first_cyc, 7);
      check("run1_idle_busy", busy, 0);
      check("run1_q_empty", exp_q.size(), 0);
      wr_done = 1'b1;

      // ready toggling 1,0,0,1
      push_stream();
      xfer_cnt = 0;
      pulse_start();
      for (int i = 0; i < 200 && !rd_done; i++) begin
         elem_ready = pat[i % 4];
         step();
      end
      elem_ready = 1'b1;
      check("run2_done", rd_done, 1);
      check("run2_xfers", xfer_cnt, 8);
      check("run2_q_empty", exp_q.size(), 0);

      // start in DONE without wr_done is ignored
      wr_done = 1'b0;
      pulse_start();
      step();
      check("done_nowr_rd_done", rd_done, 1);
      check("done_nowr_addrb", addrb, 7);
      wr_done = 1'b1;

      // reset after third transfer aborts the read
      push_stream();
      xfer_cnt = 0;
      pulse_start();
      for (int i = 0; i < 50 && xfer_cnt < 3; i++) step();
      check("abort_reached3", xfer_cnt, 3);
      reset = 1'b1;
      #1;
      check("abort_addrb", addrb, 0);
      check("abort_valid", elem_valid, 0);
      check("abort_busy",  busy, 0);
      check("abort_done",  rd_done, 0);
      check("abort_fields", {elem_data, elem_row, elem_col, elem_last}, 0);
      exp_q.delete();
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("abort_no_stale", xfer_cnt, 3);
      check("abort_idle_valid", elem_valid, 0);
      push_stream();
      xfer_cnt = 0;
      pulse_start();
      wait_done("run3_done");
      check("run3_xfers", xfer_cnt, 8);

      // restart from DONE with a mid-stream start that must be ignored
      push_stream();
      xfer_cnt = 0;
      pulse_start();
      check("run4_rd_done_fall", rd_done, 0);
      step();
      step();
      pulse_start();
      wait_done("run4_done");
      for (int i = 0; i < 5; i++) step();
      check("run4_xfers", xfer_cnt, 8);
      check("run4_q_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
